// File: rtl/fadd_rr_scheduler.sv
// fadd_rr_scheduler: round-robin front end that shares one combinational
// half-precision float_add among NUM_REQ requesters. One registered result
// slot with valid/ready on both sides; the result carries the requester ID.
// Optional statistics counters are built when FADD_SCHED_STATS_EN is defined.
// The file also carries float_add, the shared combinational adder.

module float_add #(
  parameter int float_width = 16,
  parameter int EXP_W       = 5,
  parameter int MAN_W       = 10
) (
  input  logic [float_width-1:0] a,
  input  logic [float_width-1:0] b,
  output logic [float_width-1:0] res,
  output logic [MAN_W+1:0]       fraction_sum
);
  logic             s_big, s_sml;
  logic [EXP_W-1:0] e_big, e_sml, diff;
  logic [MAN_W:0]   m_big, m_sml, m_al;
  logic [MAN_W+1:0] sum, norm;
  int               e_res, pos;

  // Align the smaller magnitude to the larger, add/subtract, renormalise.
  // Subnormal inputs count as zero; underflow and exact cancel give +0.
  always_comb begin
    if (a[float_width-2:0] >= b[float_width-2:0]) begin
      s_big = a[float_width-1];
      e_big = a[float_width-2 -: EXP_W];
      m_big = (a[float_width-2 -: EXP_W] == '0) ? '0 : {1'b1, a[MAN_W-1:0]};
      s_sml = b[float_width-1];
      e_sml = b[float_width-2 -: EXP_W];
      m_sml = (b[float_width-2 -: EXP_W] == '0) ? '0 : {1'b1, b[MAN_W-1:0]};
    end else begin
      s_big = b[float_width-1];
      e_big = b[float_width-2 -: EXP_W];
      m_big = (b[float_width-2 -: EXP_W] == '0) ? '0 : {1'b1, b[MAN_W-1:0]};
      s_sml = a[float_width-1];
      e_sml = a[float_width-2 -: EXP_W];
      m_sml = (a[float_width-2 -: EXP_W] == '0) ? '0 : {1'b1, a[MAN_W-1:0]};
    end
    diff = e_big - e_sml;
    m_al = (int'(diff) > MAN_W) ? '0 : (m_sml >> diff);
    sum  = (s_big == s_sml) ? ({1'b0, m_big} + {1'b0, m_al})
                            : ({1'b0, m_big} - {1'b0, m_al});
    pos = 0;
    for (int i = 0; i <= MAN_W; i++) begin
      if (sum[i]) pos = i;
    end
    if (sum[MAN_W+1]) begin
      norm  = sum >> 1;
      e_res = int'(e_big) + 1;
    end else begin
      norm  = sum << (MAN_W - pos);
      e_res = int'(e_big) - (MAN_W - pos);
    end
    if (sum == '0 || e_res <= 0)
      res = '0;
    else if (e_res >= (1 << EXP_W) - 1)
      res = {s_big, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    else
      res = {s_big, e_res[EXP_W-1:0], norm[MAN_W-1:0]};
  end

  assign fraction_sum = sum;
endmodule

module fadd_rr_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int FLOAT_W = 16,
  parameter int EXP_W   = 5,
  parameter int MAN_W   = 10
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*FLOAT_W-1:0]   req_a,
  input  logic [NUM_REQ*FLOAT_W-1:0]   req_b,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [FLOAT_W-1:0]           rsp_data,
  output logic [$clog2(NUM_REQ)-1:0]   rsp_id,
  output logic                         busy
`ifdef FADD_SCHED_STATS_EN
  ,
  output logic [15:0]                  op_count,
  output logic [15:0]                  stall_count
`endif
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [ID_W-1:0]    ptr_q, ptr_d, gnt_idx, ptr_nxt;
  logic               gnt_found, can_accept, accept;
  logic               valid_q, valid_d;
  logic [FLOAT_W-1:0] data_q, data_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [FLOAT_W-1:0] op_a, op_b, add_res;
  int                 idx, nxt;

  // Round-robin search from the pointer; pick the first valid requester.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    idx       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr_q) + k) % NUM_REQ;
      if (!gnt_found && req_valid[idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = idx[ID_W-1:0];
      end
    end
    nxt = int'(gnt_idx) + 1;
    if (nxt >= NUM_REQ) nxt = 0;
    ptr_nxt    = nxt[ID_W-1:0];
    can_accept = !valid_q || rsp_ready;
    accept     = gnt_found && can_accept && !flush;
    req_ready  = '0;
    if (accept) req_ready[gnt_idx] = 1'b1;
    op_a = gnt_found ? req_a[gnt_idx*FLOAT_W +: FLOAT_W] : '0;
    op_b = gnt_found ? req_b[gnt_idx*FLOAT_W +: FLOAT_W] : '0;
  end

  float_add #(
    .float_width (FLOAT_W),
    .EXP_W       (EXP_W),
    .MAN_W       (MAN_W)
  ) u_fadd (
    .a            (op_a),
    .b            (op_b),
    .res          (add_res),
    .fraction_sum ()
  );

  // Next state of the result slot: flush beats accept, accept beats consume.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    id_d    = id_q;
    ptr_d   = ptr_q;
    if (flush) begin
      valid_d = 1'b0;
      ptr_d   = '0;
    end else if (accept) begin
      valid_d = 1'b1;
      data_d  = add_res;
      id_d    = gnt_idx;
      ptr_d   = ptr_nxt;
    end else if (rsp_ready) begin
      valid_d = 1'b0;
    end
  end

  // Result slot and RR pointer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      id_q    <= '0;
      ptr_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
    end
  end

  assign rsp_valid = valid_q;
  assign rsp_data  = data_q;
  assign rsp_id    = id_q;
  assign busy      = valid_q;

`ifdef FADD_SCHED_STATS_EN
  logic [15:0] op_q, stall_q;

  // Saturating accept and stall counters, cleared by flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q    <= '0;
      stall_q <= '0;
    end else if (flush) begin
      op_q    <= '0;
      stall_q <= '0;
    end else begin
      if (accept && op_q != 16'hFFFF) op_q <= op_q + 16'd1;
      if (|req_valid && !can_accept && stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
    end
  end

  assign op_count    = op_q;
  assign stall_count = stall_q;
`endif
endmodule

// File: tb/tb_fadd_rr_scheduler.sv
// Scoreboard bench for fadd_rr_scheduler: directed scenarios followed by
// randomized requests; expected results come from real-valued arithmetic.
module tb_fadd_rr_scheduler;
  localparam int N    = 4;
  localparam int FW   = 16;
  localparam int ID_W = 2;

  logic            clk = 1'b0;
  logic            rst, flush, rsp_ready;
  logic [N-1:0]    req_valid, req_ready;
  logic [N*FW-1:0] req_a, req_b;
  logic            rsp_valid, busy;
  logic [FW-1:0]   rsp_data;
  logic [ID_W-1:0] rsp_id;
`ifdef FADD_SCHED_STATS_EN
  logic [15:0]     op_count, stall_count;
`endif

  fadd_rr_scheduler #(.NUM_REQ(N), .FLOAT_W(FW), .EXP_W(5), .MAN_W(10)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_id(rsp_id), .busy(busy)
`ifdef FADD_SCHED_STATS_EN
    , .op_count(op_count), .stall_count(stall_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [FW-1:0]   data;
  } rsp_t;

  rsp_t q[$];
  int   mp    = 0;
  int   total = 0;
  int   bad   = 0;

  logic [15:0] tbl [10] = '{16'h0000, 16'h3C00, 16'h4000, 16'h4200, 16'h4400,
                           16'h3800, 16'hBC00, 16'hC000, 16'h4500, 16'h3E00};

  function automatic real dec(input logic [15:0] h);
    real m;
    int  e;
    e = int'(h[14:10]);
    if (e == 0) return 0.0;
    m = 1.0 + real'(h[9:0]) / 1024.0;
    while (e > 15) begin m = m * 2.0; e--; end
    while (e < 15) begin m = m / 2.0; e++; end
    return h[15] ? -m : m;
  endfunction

  function automatic logic [15:0] enc(input real v);
    real m;
    int  e, man;
    logic s;
    if (v == 0.0) return 16'h0000;
    s = (v < 0.0);
    m = s ? -v : v;
    e = 15;
    while (m >= 2.0) begin m = m / 2.0; e++; end
    while (m < 1.0)  begin m = m * 2.0; e--; end
    man = int'((m - 1.0) * 1024.0);
    return {s, e[4:0], man[9:0]};
  endfunction

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h @%0t", nm, act, exp, $time);
    end
  endfunction

  task automatic clear_reqs();
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
  endtask

  task automatic set_req(input int i, input logic [15:0] a, input logic [15:0] b);
    req_valid[i]      = 1'b1;
    req_a[i*FW +: FW] = a;
    req_b[i*FW +: FW] = b;
  endtask

  // One cycle: inputs already driven just after an edge; predict the grant,
  // check it, record the expected response, advance to just after next edge.
  task automatic step(output int w);
    logic [N-1:0] er;
    int           win, id;
    rsp_t         e;
    #2;
    er  = '0;
    win = -1;
    chk("rsp_valid", rsp_valid, q.size() != 0);
    chk("busy", busy, q.size() != 0);
    if (!flush) begin
      for (int k = 0; k < N; k++) begin
        id = (mp + k) % N;
        if (win < 0 && req_valid[id]) win = id;
      end
      if (win >= 0 && (q.size() == 0 || rsp_ready)) er[win] = 1'b1;
      else win = -1;
    end
    chk("req_ready", req_ready, er);
    if (flush) begin
      q.delete();
      mp = 0;
    end else if (win >= 0) begin
      e.id   = win[ID_W-1:0];
      e.data = enc(dec(req_a[win*FW +: FW]) + dec(req_b[win*FW +: FW]));
      q.push_back(e);
      mp = (win + 1) % N;
    end
    w = win;
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare every presented response with the queue head.
  always @(negedge clk) begin
    if (!rst && !flush && rsp_valid) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rsp_unexpected actual_id=%0d actual_data=%0h required=none", rsp_id, rsp_data);
      end else begin
        chk("rsp_data", rsp_data, q[0].data);
        chk("rsp_id", rsp_id, q[0].id);
        if (rsp_ready) void'(q.pop_front());
      end
    end
  end

  initial begin
    int   w;
    bit   pv [N];
    logic [15:0] pa [N];
    logic [15:0] pb [N];
    rst = 1'b1; flush = 1'b0; rsp_ready = 1'b0;
    clear_reqs();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_rsp_data", rsp_data, 0);
    chk("reset_rsp_id", rsp_id, 0);
    chk("reset_req_ready", req_ready, 0);
    rst = 1'b0;

    // single request: 1.0 + 2.0
    set_req(0, 16'h3C00, 16'h4000); rsp_ready = 1'b1; step(w);
    clear_reqs(); step(w);

    // flush to pointer 0, then all four requesting continuously
    flush = 1'b1; step(w); flush = 1'b0;
    for (int k = 0; k < 5; k++) begin
      set_req(0, 16'h3C00, 16'h4000);
      set_req(1, 16'h4000, 16'h4000);
      set_req(2, 16'h3C00, 16'h3C00);
      set_req(3, 16'h4200, 16'h3C00);
      step(w);
    end
    clear_reqs(); step(w);

    // backpressure with req1 pending behind a held result
    rsp_ready = 1'b0;
    set_req(1, 16'h0000, 16'h4200); step(w);
    set_req(1, 16'h3C00, 16'h3C00);
    repeat (5) step(w);
    rsp_ready = 1'b1; step(w);

    // consume and grant in the same edge
    clear_reqs(); set_req(3, 16'h4400, 16'h3800); step(w);
    clear_reqs(); step(w);

    // flush while full, pointer must return to 0
    rsp_ready = 1'b0;
    set_req(0, 16'h3C00, 16'h3C00); step(w);
    clear_reqs(); set_req(0, 16'h4000, 16'h3800); set_req(3, 16'h3C00, 16'h3800);
    flush = 1'b1; step(w); flush = 1'b0;
    step(w);
    clear_reqs(); rsp_ready = 1'b1; step(w);

    // asynchronous reset in the middle of a cycle
    rsp_ready = 1'b0;
    set_req(2, 16'h4000, 16'h3C00); step(w);
    clear_reqs();
    #2 rst = 1'b1;
    #1;
    chk("async_rst_rsp_valid", rsp_valid, 0);
    chk("async_rst_rsp_data", rsp_data, 0);
    chk("async_rst_rsp_id", rsp_id, 0);
    q.delete();
    mp = 0;
    @(posedge clk);
    #1 rst = 1'b0;

    // randomized traffic with holds, drops and occasional flushes
    for (int i = 0; i < N; i++) pv[i] = 1'b0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!pv[i] && $urandom_range(0, 2) == 0) begin
          pv[i] = 1'b1;
          pa[i] = tbl[$urandom_range(0, 9)];
          pb[i] = tbl[$urandom_range(0, 9)];
        end else if (pv[i] && $urandom_range(0, 15) == 0) begin
          pv[i] = 1'b0;
        end
      end
      clear_reqs();
      for (int i = 0; i < N; i++) if (pv[i]) set_req(i, pa[i], pb[i]);
      rsp_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 40) == 0);
      step(w);
      flush = 1'b0;
      if (w >= 0) pv[w] = 1'b0;
    end

`ifdef FADD_SCHED_STATS_EN
    clear_reqs(); flush = 1'b1; step(w); flush = 1'b0;
    rsp_ready = 1'b1; set_req(0, 16'h3C00, 16'h3C00); step(w);
    clear_reqs(); set_req(1, 16'h4000, 16'h3C00); step(w);
    clear_reqs(); set_req(2, 16'h3800, 16'h3800); rsp_ready = 1'b0;
    step(w); step(w);
    rsp_ready = 1'b1; step(w);
    chk("op_count", op_count, 3);
    chk("stall_count", stall_count, 2);
    clear_reqs(); flush = 1'b1; step(w); flush = 1'b0;
    chk("op_count_flush", op_count, 0);
    chk("stall_count_flush", stall_count, 0);
`endif

    clear_reqs(); rsp_ready = 1'b1; flush = 1'b0;
    repeat (3) step(w);
    chk("drain_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
